contador_ctrl: RTL
==================

Name: contador_ctrl

Overview:
Sequencer for the 4-bit up/down counter datapath. It loads a start value, counts toward a programmed target in steps of 1 or 3 on each enabled tick, and supports pause and abort. It clamps at the target, or at 0/15 when the target is unreachable, then flags done. It sits between the board switches/buttons and the LED/7-seg/LCD outputs of the top level.

Parameters:
NBITS_COUNT, 4, counter width; all count/target/load ports use this width
STEP_BIG, 3, step size selected by step3=1 (step3=0 gives step 1)

Ports:
clk_2  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  count enable; one count step per cycle with tick=1 in COUNT
start  input  1  level sampled each cycle; starts or restarts a run
pause  input  1  level; holds the count while high
abort  input  1  level; returns to IDLE, count kept
up  input  1  direction, 1=increment, 0=decrement; latched in LOAD
step3  input  1  step select; latched in LOAD
load_val  input  NBITS_COUNT  start value; latched in LOAD
target  input  NBITS_COUNT  stop value; latched in LOAD
cnt  output  NBITS_COUNT  current count
busy  output  1  high in LOAD, COUNT, HOLD
done  output  1  high in DONE
err  output  1  high in DONE when the target was unreachable
state_o  output  3  encoded FSM state, for LCD debug

Behaviour:
- Reset (async, reset_n=0): state IDLE; cnt=0, busy=0, done=0, err=0; latched up/step3/target cleared to 0.
- Event priority each cycle: abort > start > pause > tick.
- IDLE: cnt holds. If start=1, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - cnt<=load_val; latch up, step3, target; err<=0.
  - If load_val==target, go to DONE; otherwise go to COUNT.
- COUNT:
  - pause=1: go to HOLD; cnt unchanged this cycle.
  - tick=1 and pause=0: compute next in NBITS_COUNT+1 bits.
  - up=1: next = cnt + step.
    - If cnt<target and next>=target: cnt<=target, go to DONE.
    - If cnt>target (unreachable) and next>15: cnt<=15, err<=1, go to DONE.
    - Otherwise cnt<=next.
  - up=0: same rules mirrored.
    - If cnt>target and cnt-step<=target (signed compare): cnt<=target, go to DONE.
    - If cnt<target and cnt-step<0: cnt<=0, err<=1, go to DONE.
  - No wrap-around ever.
  - tick=0: hold.
- HOLD: cnt holds. Return to COUNT on the first cycle with pause=0; tick in that cycle is ignored.
- DONE: cnt holds; done=1 level. start=1 goes to LOAD (restart). abort goes to IDLE, which clears done/err.
- abort=1 in any non-IDLE state: go to IDLE next cycle; cnt keeps its value.
- start while COUNT/HOLD with abort=0: restart via LOAD.
- Reset mid-run: immediate return to reset values.
- Latency: the first count step occurs at the earliest 2 cycles after start is sampled (LOAD, then COUNT with tick).
- state_o encoding: IDLE=0, LOAD=1, COUNT=2, HOLD=3, DONE=4.

Optional Feature:
CONTADOR_CTRL_SEG_EN
- Defined: adds output port seg [7:0], the registered 7-segment hex pattern of cnt. seg updates one cycle after cnt and is 'h3f after reset.
- Undefined: the seg port and its logic are absent.

Decomposition:
- Package contador_pkg: state enum state_t (IDLE, LOAD, COUNT, HOLD, DONE, with the codes above); 7-seg constants NUM_0..NUM_9, LETRA_A..LETRA_F; a function hex_to_seg.
- Sub-module contador_dp: the counter register with load/step/clamp arithmetic, driven by control signals (load, en, up, step3, clamp value) from the FSM in contador_ctrl.

Test Plan:
- Reset: reset_n=0 mid-COUNT at cnt=7 -> cnt=0, busy=0, done=0, state_o=0 asynchronously.
- Up run: load_val=2, target=9, up=1, step3=0, tick=1 constant -> cnt 2,3,...,9; done=1 at 9; busy=0; err=0.
- Step-3 clamp up: load_val=1, target=8, step3=1 -> cnt 1,4,7,8; done; err=0.
- Step-3 clamp down: load_val=14, target=10, up=0, step3=1 -> cnt 14,11,10; done.
- Unreachable target: load_val=12, target=3, up=1, step3=1 -> cnt 12,15; done=1, err=1. Then abort -> IDLE, err=0, cnt=15.
- Pause/abort/priority: pause for 3 cycles at cnt=5 -> cnt stays 5 and state_o=3, resumes one cycle after release. start and abort asserted together in COUNT -> IDLE. load_val==target=6 -> DONE directly after LOAD.

Source files
------------

// File: rtl/contador_pkg.sv
// contador_pkg: shared types and helpers for the contador_ctrl sequencer.
//   state_t     - FSM state codes; the numeric values are exported on state_o
//                 and shown on the LCD debug view.
//   NUM_*/LETRA_* - 7-segment patterns, active-high, bit order {dp,g,f,e,d,c,b,a}.
//   hex_to_seg  - maps a 4-bit value to its 7-segment hex glyph.
package contador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] NUM_0   = 8'h3f;
  localparam logic [7:0] NUM_1   = 8'h06;
  localparam logic [7:0] NUM_2   = 8'h5b;
  localparam logic [7:0] NUM_3   = 8'h4f;
  localparam logic [7:0] NUM_4   = 8'h66;
  localparam logic [7:0] NUM_5   = 8'h6d;
  localparam logic [7:0] NUM_6   = 8'h7d;
  localparam logic [7:0] NUM_7   = 8'h07;
  localparam logic [7:0] NUM_8   = 8'h7f;
  localparam logic [7:0] NUM_9   = 8'h6f;
  localparam logic [7:0] LETRA_A = 8'h77;
  localparam logic [7:0] LETRA_B = 8'h7c;
  localparam logic [7:0] LETRA_C = 8'h39;
  localparam logic [7:0] LETRA_D = 8'h5e;
  localparam logic [7:0] LETRA_E = 8'h79;
  localparam logic [7:0] LETRA_F = 8'h71;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = NUM_0;
      4'h1:    s = NUM_1;
      4'h2:    s = NUM_2;
      4'h3:    s = NUM_3;
      4'h4:    s = NUM_4;
      4'h5:    s = NUM_5;
      4'h6:    s = NUM_6;
      4'h7:    s = NUM_7;
      4'h8:    s = NUM_8;
      4'h9:    s = NUM_9;
      4'ha:    s = LETRA_A;
      4'hb:    s = LETRA_B;
      4'hc:    s = LETRA_C;
      4'hd:    s = LETRA_D;
      4'he:    s = LETRA_E;
      default: s = LETRA_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_dp.sv
// contador_dp: count register plus step/clamp arithmetic.
//   clk_i, rst_ni        - clock, async active-low reset (count clears to 0)
//   load_i, load_val_i   - load the start value (has priority over en_i)
//   en_i                 - apply one step (or the clamp value) this cycle
//   up_i, step3_i        - direction and step size (1 or STEP_BIG)
//   target_i             - stop value used for the reach/overrun flags
//   clamp_i, clamp_val_i - replace the stepped value with clamp_val_i
//   cnt_o                - current count
//   hit_o                - this step reaches or passes the target
//   oob_o                - this step would leave [0, 2^N-1] with the target behind us
module contador_dp
  import contador_pkg::*;
#(
  parameter int unsigned NBITS_COUNT = 4,
  parameter int unsigned STEP_BIG    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [NBITS_COUNT-1:0] load_val_i,
  input  logic                   en_i,
  input  logic                   up_i,
  input  logic                   step3_i,
  input  logic [NBITS_COUNT-1:0] target_i,
  input  logic                   clamp_i,
  input  logic [NBITS_COUNT-1:0] clamp_val_i,
  output logic [NBITS_COUNT-1:0] cnt_o,
  output logic                   hit_o,
  output logic                   oob_o
);

  localparam int unsigned W = NBITS_COUNT + 1;

  logic [NBITS_COUNT-1:0] cnt_q, cnt_d;
  logic [W-1:0]           step_w, sum_w;
  logic signed [W:0]      diff_s;
  logic                   up_hit, up_oob, dn_hit, dn_oob;

  always_comb begin
    step_w = step3_i ? W'(STEP_BIG) : W'(1);
    // One spare bit catches overflow above 2^N-1; the signed
    // difference carries a sign bit so underflow below 0 is visible.
    sum_w  = {1'b0, cnt_q} + step_w;
    diff_s = $signed({2'b00, cnt_q}) - $signed({1'b0, step_w});

    up_hit = (cnt_q < target_i) && (sum_w >= {1'b0, target_i});
    up_oob = (cnt_q > target_i) && sum_w[NBITS_COUNT];
    dn_hit = (cnt_q > target_i) && (diff_s <= $signed({2'b00, target_i}));
    dn_oob = (cnt_q < target_i) && diff_s[W];

    hit_o  = up_i ? up_hit : dn_hit;
    oob_o  = up_i ? up_oob : dn_oob;

    if (clamp_i) begin
      cnt_d = clamp_val_i;
    end else if (up_i) begin
      cnt_d = sum_w[NBITS_COUNT-1:0];
    end else begin
      cnt_d = diff_s[NBITS_COUNT-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/contador_ctrl.sv
// contador_ctrl: sequencer for the up/down counter datapath.
// Loads a start value, steps toward a target by 1 or STEP_BIG per tick,
// clamps at the target (or at 0 / 2^N-1 when the target lies behind the
// direction of travel) and then flags done. Priority: abort > start > pause > tick.
//   clk_2, reset_n   - clock, async active-low reset
//   tick             - count enable in COUNT
//   start            - start / restart a run (through LOAD)
//   pause            - hold the count while high
//   abort            - back to IDLE, count kept
//   up, step3        - direction and step select, latched in LOAD
//   load_val, target - start and stop values, latched in LOAD
//   cnt              - current count
//   busy/done/err    - LOAD|COUNT|HOLD / DONE / DONE with unreachable target
//   state_o          - state code for LCD debug
//   seg              - registered 7-seg glyph of cnt (only with CONTADOR_CTRL_SEG_EN)
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int unsigned NBITS_COUNT = 4,
  parameter int unsigned STEP_BIG    = 3
) (
  input  logic                   clk_2,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic                   up,
  input  logic                   step3,
  input  logic [NBITS_COUNT-1:0] load_val,
  input  logic [NBITS_COUNT-1:0] target,
  output logic [NBITS_COUNT-1:0] cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             state_o
`ifdef CONTADOR_CTRL_SEG_EN
  ,
  output logic [7:0]             seg
`endif
);

  state_t                 state_q, state_d;
  logic                   up_q, step3_q;
  logic [NBITS_COUNT-1:0] target_q;
  logic                   busy_q, done_q, err_q, err_d;
  logic                   dp_load, dp_en, dp_clamp, dp_hit, dp_oob;
  logic [NBITS_COUNT-1:0] clamp_val;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    dp_load = 1'b0;
    dp_en   = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start && !abort) state_d = LOAD;
        LOAD: begin
          dp_load = 1'b1;
          state_d = (load_val == target) ? DONE : COUNT;
        end
        COUNT: begin
          if (start) begin
            state_d = LOAD;
          end else if (pause) begin
            state_d = HOLD;
          end else if (tick) begin
            dp_en = 1'b1;
            if (dp_hit || dp_oob) begin
              state_d = DONE;
              err_d   = dp_oob;
            end
          end
        end
        HOLD: begin
          if (start) begin
            state_d = LOAD;
          end else if (!pause) begin
            state_d = COUNT;
          end
        end
        DONE: begin
          if (start) begin
            state_d = LOAD;
          end else begin
            err_d = err_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Clamp to the target when reached, otherwise to the rail we ran into.
  assign dp_clamp  = dp_hit | dp_oob;
  assign clamp_val = dp_hit ? target_q : (up_q ? '1 : '0);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      up_q     <= 1'b0;
      step3_q  <= 1'b0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == LOAD) || (state_d == COUNT) || (state_d == HOLD);
      done_q  <= (state_d == DONE);
      err_q   <= err_d;
      if (dp_load) begin
        up_q     <= up;
        step3_q  <= step3;
        target_q <= target;
      end
    end
  end

  contador_dp #(
    .NBITS_COUNT (NBITS_COUNT),
    .STEP_BIG    (STEP_BIG)
  ) u_dp (
    .clk_i       (clk_2),
    .rst_ni      (reset_n),
    .load_i      (dp_load),
    .load_val_i  (load_val),
    .en_i        (dp_en),
    .up_i        (up_q),
    .step3_i     (step3_q),
    .target_i    (target_q),
    .clamp_i     (dp_clamp),
    .clamp_val_i (clamp_val),
    .cnt_o       (cnt),
    .hit_o       (dp_hit),
    .oob_o       (dp_oob)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

`ifdef CONTADOR_CTRL_SEG_EN
  logic [7:0] seg_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= NUM_0;
    end else begin
      seg_q <= hex_to_seg(cnt[3:0]);
    end
  end

  assign seg = seg_q;
`endif

endmodule
